// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer
//   Buffers 8-bit ADC capture samples in a synchronous FIFO on the fabric clock.
//   Each stored entry carries a start-of-frame tag that comes from a per-frame
//   sample counter. The block also reports the fill level, full/empty, a sticky
//   overflow flag and a saturating count of dropped samples.
//
// Ports
//   clk           fabric clock
//   reset         asynchronous active-low reset (assert async, release sync)
//   din/din_valid sample from the capture stage plus its one-cycle qualifier
//   frame_sync    restarts frame sample numbering
//   rd_en         read request; data appears one cycle after an accepted read
//   clr_overflow  clears overflow and drop_count
//   dout/dout_sof registered read data and its start-of-frame tag
//   dout_valid    dout/dout_sof updated this cycle
//   empty/full    registered status flags, updated together with level
//   level         stored entry count, 0..DEPTH
//   overflow      sticky flag, set when a sample is dropped
//   drop_count    saturating count of dropped samples
module adc_sample_buffer #(
    parameter int DEPTH             = 64,
    parameter int AW                = 6,
    parameter int SAMPLES_PER_FRAME = 112,
    parameter int DROP_W            = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              frame_sync,
    input  logic              rd_en,
    input  logic              clr_overflow,
    output logic [7:0]        dout,
    output logic              dout_sof,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    // Reset synchroniser: assertion reaches the core at once, and release is
    // aligned to clk so that no flop leaves reset close to a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [8:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic [7:0]        dout_q, dout_d;
    logic              dout_sof_q, dout_sof_d, dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic [15:0]       fcnt_q, fcnt_d, fcnt_base;

    logic rd_accept, wr_accept, drop, sof;

    // A full FIFO can still accept a write when a read frees a slot in the
    // same cycle. A sample is dropped only when full and no read is requested.
    assign rd_accept = rd_en & ~empty_q;
    assign wr_accept = din_valid & (~full_q | rd_accept);
    assign drop      = din_valid & full_q & ~rd_en;

    // frame_sync arriving together with a sample makes that sample the
    // frame start.
    assign fcnt_base = frame_sync ? 16'd0 : fcnt_q;
    assign sof       = (fcnt_base == 16'd0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        dout_d       = dout_q;
        dout_sof_d   = dout_sof_q;
        dout_valid_d = rd_accept;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        fcnt_d       = fcnt_base;

        if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_accept) begin
            rd_ptr_d              = rd_ptr_q + AW'(1);
            {dout_sof_d, dout_d}  = mem[rd_ptr_q];
        end

        case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        empty_d = (level_d == '0);
        full_d  = (level_d == (AW+1)'(DEPTH));

        // The frame counter advances on every sample, including dropped
        // ones, so frame numbering stays aligned with the source.
        if (din_valid)
            fcnt_d = (fcnt_base == 16'(SAMPLES_PER_FRAME - 1)) ? 16'd0 : fcnt_base + 16'd1;

        // When a drop and a clear happen in the same cycle, the drop wins
        // and is counted from zero.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)       drop_count_d = DROP_W'(1);
            else if (~&drop_count_q) drop_count_d = drop_count_q + DROP_W'(1);
        end else if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // Sample storage has no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= {sof, din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            dout_q       <= '0;
            dout_sof_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            fcnt_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            dout_q       <= dout_d;
            dout_sof_q   <= dout_sof_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_sof   = dout_sof_q;
    assign dout_valid = dout_valid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer. Two instances share the same inputs:
// u_a uses the default configuration (DEPTH=64, 112 samples per frame), and
// u_b is small (DEPTH=4, 3 samples per frame) so that full, drop and frame
// wrap conditions are easy to reach.
module tb_adc_sample_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0, frame_sync = 1'b0, rd_en = 1'b0, clr_overflow = 1'b0;

    logic [7:0] a_dout, b_dout;
    logic       a_sof, a_vld, a_empty, a_full, a_ovf;
    logic       b_sof, b_vld, b_empty, b_full, b_ovf;
    logic [6:0] a_level;
    logic [2:0] b_level;
    logic [7:0] a_drop, b_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_sample_buffer u_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .rd_en(rd_en), .clr_overflow(clr_overflow),
        .dout(a_dout), .dout_sof(a_sof), .dout_valid(a_vld), .empty(a_empty),
        .full(a_full), .level(a_level), .overflow(a_ovf), .drop_count(a_drop)
    );

    adc_sample_buffer #(.DEPTH(4), .AW(2), .SAMPLES_PER_FRAME(3), .DROP_W(8)) u_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .rd_en(rd_en), .clr_overflow(clr_overflow),
        .dout(b_dout), .dout_sof(b_sof), .dout_valid(b_vld), .empty(b_empty),
        .full(b_full), .level(b_level), .overflow(b_ovf), .drop_count(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic wr(input logic [7:0] d);
        din = d; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // mode 0: no sync; 1: frame_sync alone before the 3rd write;
    // 2: frame_sync together with the 3rd write.
    task automatic sof_run(input int mode);
        int e[7];
        if (mode == 0) e = '{1, 0, 0, 1, 0, 0, 1};
        else           e = '{1, 0, 1, 0, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (mode == 2 && k == 2) frame_sync = 1'b1;
            wr(8'(k));
            frame_sync = 1'b0;
            if (mode == 1 && k == 1) frame_sync = 1'b1;
            rd_en = 1'b1;
            step();
            rd_en = 1'b0; frame_sync = 1'b0;
            chk($sformatf("sof m%0d s%0d", mode, k), b_sof, e[k]);
        end
    endtask

    initial begin
        // reset state
        step();
        chk("rst empty", a_empty, 1);
        chk("rst full", a_full, 0);
        chk("rst level", a_level, 0);
        chk("rst vld", a_vld, 0);
        chk("rst dout", a_dout, 0);
        chk("rst ovf", a_ovf, 0);
        chk("rst drop", a_drop, 0);
        reset = 1'b1;
        repeat (3) step();

        // basic write 5 / read 5 on the deep instance
        for (int i = 1; i <= 5; i++) wr(8'(i));
        chk("t1 level5", a_level, 5);
        for (int i = 1; i <= 5; i++) begin
            rd_en = 1'b1;
            step();
            chk("t1 dout", a_dout, i);
            chk("t1 vld", a_vld, 1);
            chk("t1 sof", a_sof, (i == 1) ? 1 : 0);
        end
        rd_en = 1'b0;
        step();
        chk("t1 vld off", a_vld, 0);
        chk("t1 level0", a_level, 0);
        chk("t1 empty", a_empty, 1);

        // overflow on the small instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr(8'(8'h10 + i));
            if (i == 3) chk("t2 full", b_full, 1);
        end
        chk("t2 ovf", b_ovf, 1);
        chk("t2 drop", b_drop, 2);
        chk("t2 level", b_level, 4);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            chk("t2 dout", b_dout, 8'h10 + i);
        end
        rd_en = 1'b0;

        // simultaneous read/write when full and when empty
        for (int i = 0; i < 4; i++) wr(8'(8'h20 + i));
        din = 8'h24; din_valid = 1'b1; rd_en = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t3 full rw dout", b_dout, 8'h20);
        chk("t3 full rw level", b_level, 4);
        chk("t3 full rw drop", b_drop, 2);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t3 order", b_dout, 8'h20 + i);
        end
        rd_en = 1'b0;
        chk("t3 drained", b_level, 0);
        din = 8'h30; din_valid = 1'b1; rd_en = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t3 empty rw vld", b_vld, 0);
        chk("t3 empty rw level", b_level, 1);
        step();
        rd_en = 1'b0;
        chk("t3 late read", b_dout, 8'h30);
        chk("t3 late vld", b_vld, 1);

        // frame tagging
        sof_run(0);
        sof_run(1);
        sof_run(2);

        // drop counter saturation and clearing
        do_reset();
        din = 8'hAA; din_valid = 1'b1;
        repeat (304) step();
        din_valid = 1'b0;
        chk("t5 sat", b_drop, 255);
        chk("t5 ovf", b_ovf, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t5 clr drop", b_drop, 0);
        chk("t5 clr ovf", b_ovf, 0);
        clr_overflow = 1'b1; din_valid = 1'b1;
        step();
        clr_overflow = 1'b0; din_valid = 1'b0;
        chk("t5 clr+drop cnt", b_drop, 1);
        chk("t5 clr+drop ovf", b_ovf, 1);

        // asynchronous reset in mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("t6 pre level", b_level, 3);
        chk("t6 pre vld", b_vld, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6 async vld", b_vld, 0);
        chk("t6 async level", b_level, 0);
        chk("t6 async empty", b_empty, 1);
        chk("t6 async full", b_full, 0);
        chk("t6 async dout", b_dout, 0);
        chk("t6 async ovf", b_ovf, 0);
        chk("t6 async drop", b_drop, 0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        chk("t6 post empty", b_empty, 1);
        wr(8'h55);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("t6 post dout", b_dout, 8'h55);
        chk("t6 post sof", b_sof, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
